// File: rtl/uart_pkg.sv
// Shared types and constants for the 7-bit-data, parity, 1-stop UART receive path.
package uart_pkg;

    localparam int DATA_BITS  = 7;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the serial line; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: start, 7 data bits LSB first, parity, stop; 16x oversampled.
//   state     | meaning
//   ST_IDLE   | waiting for rxd_s low on a tick
//   ST_START  | counting to mid start bit, rejects glitches
//   ST_DATA   | sampling 7 data bits mid-bit
//   ST_PARITY | sampling the parity bit
//   ST_STOP   | sampling stop, publishing the frame, back to idle mid-stop
import uart_pkg::*;

module uart_rx_deframer #(
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick_16x,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [3:0] TICK_MID  = 4'(MID_TICK);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    uart_state_t          state, state_nxt;
    logic [3:0]           tick_cnt, tick_cnt_nxt;
    logic [2:0]           bit_idx, bit_idx_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_nxt;
    logic                 par_bit, par_bit_nxt;
    logic [DATA_BITS-1:0] data_out_nxt;
    logic                 data_valid_nxt, parity_err_nxt, frame_err_nxt;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_reg_nxt;
            par_bit    <= par_bit_nxt;
            data_out   <= data_out_nxt;
            data_valid <= data_valid_nxt;
            parity_err <= parity_err_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_cnt;
        bit_idx_nxt    = bit_idx;
        shift_reg_nxt  = shift_reg;
        par_bit_nxt    = par_bit;
        data_out_nxt   = data_out;
        data_valid_nxt = 1'b0;
        parity_err_nxt = parity_err;
        frame_err_nxt  = frame_err;

        if (baud_tick_16x) begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        tick_cnt_nxt = '0;
                        state_nxt    = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_cnt == TICK_MID) begin
                        if (rxd_s) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            tick_cnt_nxt = '0;
                            bit_idx_nxt  = '0;
                            state_nxt    = ST_DATA;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        shift_reg_nxt = {rxd_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == IDX_LAST) state_nxt = ST_PARITY;
                        else bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
                ST_PARITY: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    if (tick_cnt == TICK_LAST) begin
                        par_bit_nxt = rxd_s;
                        state_nxt   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    tick_cnt_nxt = tick_cnt + 4'd1;
                    // Leaving at mid-stop lets a back-to-back start bit be caught on time.
                    if (tick_cnt == TICK_LAST) begin
                        data_out_nxt   = shift_reg;
                        parity_err_nxt = (par_bit != ((^shift_reg) ^ PARITY_ODD));
                        frame_err_nxt  = ~rxd_s;
                        data_valid_nxt = 1'b1;
                        state_nxt      = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
